// File: rtl/mmio_periph.sv
// Memory-mapped peripheral: compare timer with interrupt, byte-wide TX FIFO drained
// over a valid/ready stream, and a RESULT register exported as the pass/fail value.
module mmio_periph #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        hit_o,
    output logic        irq_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic [31:0] verify_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_COUNT   = 3'd1;
    localparam logic [2:0] OFF_COMPARE = 3'd2;
    localparam logic [2:0] OFF_STATUS  = 3'd3;
    localparam logic [2:0] OFF_TXDATA  = 3'd4;
    localparam logic [2:0] OFF_RESULT  = 3'd5;

    // Stream handshake: a byte moves on every rising edge where tx_valid_o and
    // tx_ready_i are both high; tx_data_o holds while valid is high and ready is low.

    logic        hit;
    logic        wr;
    logic [2:0]  off;

    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        match_q, match_d;
    logic        ovf_q, ovf_d;
    logic [31:0] result_q, result_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    logic        en;
    logic        autoreload;
    logic        irqen;
    logic        match_now;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        push_ok;
    logic        push_drop;
    logic [31:0] level_ext;
    logic [3:0]  level_field;
    logic [31:0] status_word;
    logic [31:0] rdata;

    // Decode is masked during reset so the read mux and hit_o stay quiet.
    assign off = addr_i[4:2];
    assign hit = rst & ce_i & (addr_i[31:5] == BASE_ADDR[31:5]);
    assign wr  = hit & we_i;

    assign en         = ctrl_q[0];
    assign autoreload = ctrl_q[1];
    assign irqen      = ctrl_q[2];
    assign match_now  = en & (count_q == compare_q);

    assign full      = (level_q == LW'(FIFO_DEPTH));
    assign empty     = (level_q == '0);
    assign pop       = ~empty & tx_ready_i;
    assign push      = wr & (off == OFF_TXDATA);
    assign push_ok   = push & (~full | pop);
    assign push_drop = push & full & ~pop;

    assign level_ext   = 32'(level_q);
    assign level_field = (level_ext > 32'd15) ? 4'hF : level_ext[3:0];
    assign status_word = {24'h0, level_field, ovf_q, empty, full, match_q};

    always_comb begin
        rdata = 32'h0;
        if (hit && !we_i) begin
            case (off)
                OFF_CTRL:    rdata = {29'h0, ctrl_q};
                OFF_COUNT:   rdata = count_q;
                OFF_COMPARE: rdata = compare_q;
                OFF_STATUS:  rdata = status_word;
                OFF_RESULT:  rdata = result_q;
                default:     rdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        compare_d = compare_q;
        result_d  = result_q;
        count_d   = count_q;
        match_d   = match_q;
        ovf_d     = ovf_q;

        if (wr && off == OFF_CTRL)    ctrl_d    = data_i[2:0];
        if (wr && off == OFF_COMPARE) compare_d = data_i;
        if (wr && off == OFF_RESULT)  result_d  = data_i;

        // A core write to COUNT beats both reload and increment.
        if (wr && off == OFF_COUNT)   count_d = data_i;
        else if (match_now && autoreload) count_d = 32'h0;
        else if (en)                  count_d = count_q + 32'd1;

        // W1C clears first so a coincident set event wins.
        if (wr && off == OFF_STATUS && data_i[0]) match_d = 1'b0;
        if (match_now)                            match_d = 1'b1;
        if (wr && off == OFF_STATUS && data_i[3]) ovf_d = 1'b0;
        if (push_drop)                            ovf_d = 1'b1;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_ok && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push_ok) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q    <= 3'h0;
            count_q   <= 32'h0;
            compare_q <= 32'h0;
            match_q   <= 1'b0;
            ovf_q     <= 1'b0;
            result_q  <= 32'h0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
            ovf_q     <= ovf_d;
            result_q  <= result_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i[7:0];
        end
    end

    assign data_o     = rdata;
    assign hit_o      = hit;
    assign irq_o      = match_q & irqen;
    assign tx_valid_o = ~empty;
    assign tx_data_o  = empty ? 8'h0 : mem_q[rd_ptr_q];
    assign verify_o   = result_q;

endmodule

// File: tb/tb_mmio_periph.sv
// Bench for mmio_periph: directed test-plan sequences plus random traffic, all
// checked every cycle against a register/queue level model of the peripheral.
module tb_mmio_periph;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        hit_o;
  logic        irq_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i;
  logic [31:0] verify_o;

  int n_checks = 0;
  int n_fail = 0;
  logic rdy_v = 1'b0;

  mmio_periph #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
    .data_i(data_i), .data_o(data_o), .hit_o(hit_o), .irq_o(irq_o),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .verify_o(verify_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge.
  task automatic drive(input logic ce, input logic we, input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    ce_i = ce; we_i = we; addr_i = addr; data_i = data; tx_ready_i = rdy_v;
  endtask

  task automatic wr(input logic [4:0] o, input logic [31:0] d);
    drive(1'b1, 1'b1, BASE + 32'(o), d);
  endtask

  task automatic rd(input logic [4:0] o);
    drive(1'b1, 1'b0, BASE + 32'(o), 32'h0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  logic [2:0]  m_ctrl;
  logic [31:0] m_count, m_compare, m_result;
  logic        m_match, m_ovf;
  logic [7:0]  exp_q[$];

  function automatic logic [31:0] m_read(input logic [2:0] o);
    int n;
    n = exp_q.size();
    case (o)
      3'd0: return {29'h0, m_ctrl};
      3'd1: return m_count;
      3'd2: return m_compare;
      3'd3: return {24'h0, 4'(n), m_ovf, (n == 0), (n == DEPTH), m_match};
      3'd5: return m_result;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 3'h0; m_count = 32'h0; m_compare = 32'h0; m_result = 32'h0;
    m_match = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
  endtask

  // Compare process: outputs on the falling edge, then advance the model by one edge.
  always @(negedge clk) begin : compare_proc
    logic mhit, w, mm, pop, was_full;
    logic [2:0] o;
    logic [31:0] n_count;
    logic n_match, n_ovf;
    if (!rst) begin
      check("rst_data", data_o, 32'h0);
      check("rst_hit", 32'(hit_o), 32'h0);
      check("rst_irq", 32'(irq_o), 32'h0);
      check("rst_valid", 32'(tx_valid_o), 32'h0);
      check("rst_txdata", 32'(tx_data_o), 32'h0);
      check("rst_verify", verify_o, 32'h0);
      model_reset();
    end else begin
      mhit = ce_i && (addr_i[31:5] == BASE[31:5]);
      o = addr_i[4:2];
      w = mhit && we_i;
      check("hit", 32'(hit_o), 32'(mhit));
      check("data", data_o, (mhit && !we_i) ? m_read(o) : 32'h0);
      check("irq", 32'(irq_o), 32'(m_match && m_ctrl[2]));
      check("valid", 32'(tx_valid_o), 32'(exp_q.size() != 0));
      check("txdata", 32'(tx_data_o), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
      check("verify", verify_o, m_result);

      mm = m_ctrl[0] && (m_count == m_compare);
      n_count = m_count;
      if (w && o == 3'd1) n_count = data_i;
      else if (mm && m_ctrl[1]) n_count = 32'h0;
      else if (m_ctrl[0]) n_count = m_count + 32'd1;
      n_match = m_match;
      if (w && o == 3'd3 && data_i[0]) n_match = 1'b0;
      if (mm) n_match = 1'b1;
      n_ovf = m_ovf;
      if (w && o == 3'd3 && data_i[3]) n_ovf = 1'b0;
      was_full = (exp_q.size() == DEPTH);
      pop = (exp_q.size() != 0) && tx_ready_i;
      if (pop) void'(exp_q.pop_front());
      if (w && o == 3'd4) begin
        if (!was_full || pop) exp_q.push_back(data_i[7:0]);
        else n_ovf = 1'b1;
      end
      if (w && o == 3'd0) m_ctrl = data_i[2:0];
      if (w && o == 3'd2) m_compare = data_i;
      if (w && o == 3'd5) m_result = data_i;
      m_count = n_count; m_match = n_match; m_ovf = n_ovf;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; ce_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; data_i = 32'h0; tx_ready_i = 1'b0;
    model_reset();

    // Reset held with ce toggling against the window.
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 1'b0, BASE + 32'h0C, 32'h0);
      #1;
      check("reset_data_lit", data_o, 32'h0);
      check("reset_hit_lit", 32'(hit_o), 32'h0);
    end
    @(posedge clk); #1; rst = 1'b1; ce_i = 1'b0;
    rd(5'h0C); #1; check("status_after_reset", data_o, 32'h0000_0004);

    // Timer one-shot.
    wr(5'h04, 32'd0); wr(5'h08, 32'd5); wr(5'h00, 32'd5);
    for (int i = 0; i < 8; i++) begin
      rd(5'h04); #1;
      check("oneshot_count", data_o, 32'(i));
      check("oneshot_irq", 32'(irq_o), 32'(i >= 6));
    end
    wr(5'h0C, 32'd1);
    rd(5'h0C); #1;
    check("w1c_irq", 32'(irq_o), 32'h0);
    check("w1c_status", data_o, 32'h0000_0004);
    wr(5'h00, 32'd0);

    // Autoreload with a W1C colliding with a match.
    wr(5'h04, 32'd0); wr(5'h0C, 32'd1); wr(5'h08, 32'd3); wr(5'h00, 32'd3);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        wr(5'h0C, 32'd1);
      end else if (i == 4) begin
        rd(5'h0C); #1; check("set_wins_status", data_o, 32'h0000_0005);
      end else begin
        rd(5'h04); #1; check("reload_count", data_o, 32'(i % 4));
      end
    end
    wr(5'h00, 32'd0); wr(5'h0C, 32'd1);

    // FIFO fill and overflow.
    rdy_v = 1'b0;
    for (int i = 0; i < 9; i++) wr(5'h10, 32'h11 + 32'(i));
    rd(5'h0C); #1;
    check("full_status", data_o, 32'h0000_008A);
    check("full_head", 32'(tx_data_o), 32'h11);
    rdy_v = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idle(); #1;
      check("drain_byte", 32'(tx_data_o), 32'h11 + 32'(i));
    end
    idle(); #1; check("drain_empty", 32'(tx_valid_o), 32'h0);
    rd(5'h0C); #1; check("ovf_status", data_o, 32'h0000_000C);
    wr(5'h0C, 32'h8);

    // Push and pop together while full.
    rdy_v = 1'b0;
    for (int i = 0; i < 8; i++) wr(5'h10, 32'h20 + 32'(i));
    rdy_v = 1'b1;
    wr(5'h10, 32'hAA);
    rd(5'h0C); #1;
    check("pushpop_status", data_o, 32'h0000_0082);
    check("pushpop_head", 32'(tx_data_o), 32'h21);
    for (int j = 0; j < 7; j++) begin
      idle(); #1;
      check("pushpop_byte", 32'(tx_data_o), (j < 6) ? 32'h22 + 32'(j) : 32'hAA);
    end
    idle(); #1; check("pushpop_empty", 32'(tx_valid_o), 32'h0);

    // RESULT and decode boundary.
    wr(5'h14, 32'd1);
    idle(); #1; check("verify_set", verify_o, 32'd1);
    drive(1'b1, 1'b1, BASE + 32'h34, 32'd7); #1;
    check("outside_hit", 32'(hit_o), 32'h0);
    idle(); #1; check("verify_unchanged", verify_o, 32'd1);
    rd(5'h18); #1;
    check("reserved_read", data_o, 32'h0);
    check("reserved_hit", 32'(hit_o), 32'h1);

    // Reset during a pending transfer.
    rdy_v = 1'b0;
    wr(5'h10, 32'h5A); wr(5'h10, 32'h5B); wr(5'h14, 32'h55);
    @(posedge clk); #3;
    rst = 1'b0; ce_i = 1'b0; we_i = 1'b0;
    #1;
    check("async_valid", 32'(tx_valid_o), 32'h0);
    check("async_txdata", 32'(tx_data_o), 32'h0);
    check("async_verify", verify_o, 32'h0);
    repeat (2) @(posedge clk);
    @(posedge clk); #1; rst = 1'b1;
    rd(5'h0C); #1; check("status_after_async", data_o, 32'h0000_0004);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      logic ce, we;
      logic [2:0] o;
      logic [31:0] a, d;
      ce = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1) == 1;
      o = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else if ($urandom_range(0, 9) == 0) a = BASE + 32'h20 + 32'({o, 2'b00});
      else a = BASE + 32'({o, 2'b00}) + 32'($urandom_range(0, 3));
      if (o == 3'd1 || o == 3'd2) d = 32'($urandom_range(0, 20));
      else d = $urandom;
      rdy_v = ($urandom_range(0, 2) == 0);
      drive(ce, we, a, d);
    end

    idle(); idle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
